// File: rtl/wb_stage_q.sv
// Registered write-back stage: aligns LSU load data, queues results in a FIFO and
// drains them into the register-file port. Define WB_FWD_EN to enable forwarding from queued results.
module wb_stage_q #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [XLEN-1:0]   in_alu_data,
    input  logic              in_mem_sel,
    input  logic [XLEN-1:0]   in_mem_rdata,
    input  logic [XLEN/8-1:0] in_rstrb,
    input  logic              in_lsign,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_rd_wen,
    input  logic              wb_stall,
    output logic [RA_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_rd_data,
    output logic              wb_rd_wen,
    output logic              wb_align_err,
    output logic [CNT_W-1:0]  retire_cnt,
    input  logic [RA_W-1:0]   fwd_rs,
    output logic              fwd_hit,
    output logic [XLEN-1:0]   fwd_data
);

    localparam int SW     = XLEN / 8;
    localparam int LOG_SW = $clog2(SW);
    localparam int PW     = $clog2(DEPTH);

    logic [RA_W-1:0]  mem_rd   [DEPTH];
    logic [XLEN-1:0]  mem_data [DEPTH];
    logic             mem_wen  [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [CNT_W-1:0] retire_q;
    logic             align_err_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [XLEN-1:0]  aligned;
    logic             strb_ok;
    logic [SW-1:0]    lane_mask;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  fmask;
    logic             msb;

    assign full   = (count == (PW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign in_rdy = ~full & ~RST;
    assign push   = in_vld & in_rdy;
    assign pop    = ~empty & ~wb_stall & ~RST;

    // Only a single naturally aligned run of 1/2/4(/8) lanes is a legal partial strobe.
    always_comb begin
        aligned   = in_mem_rdata;
        strb_ok   = 1'b0;
        lane_mask = '0;
        shifted   = '0;
        fmask     = '0;
        msb       = 1'b0;
        if (!in_mem_sel) begin
            aligned = in_alu_data;
            strb_ok = 1'b1;
        end else if (in_rstrb == '0 || in_rstrb == '1) begin
            strb_ok = 1'b1;
        end else begin
            for (int k = 0; k < LOG_SW; k++) begin
                for (int off = 0; off < SW; off++) begin
                    lane_mask = SW'((1 << (1 << k)) - 1) << off;
                    if ((off % (1 << k)) == 0 && in_rstrb == lane_mask) begin
                        shifted = in_mem_rdata >> (8 * off);
                        fmask   = {XLEN{1'b1}} >> (XLEN - 8 * (1 << k));
                        msb     = |(shifted & fmask & ~(fmask >> 1));
                        aligned = (shifted & fmask) | ((in_lsign && msb) ? ~fmask : '0);
                        strb_ok = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            retire_q    <= '0;
            align_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                retire_q <= retire_q + CNT_W'(1);
            end
            count       <= count + (PW+1)'(push) - (PW+1)'(pop);
            align_err_q <= push & ~strb_ok;
        end
    end

    // Storage needs no reset: count alone decides which slots are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_rd[wr_ptr]   <= in_rd;
            mem_data[wr_ptr] <= aligned;
            mem_wen[wr_ptr]  <= in_rd_wen & (in_rd != '0);
        end
    end

    assign wb_rd        = (empty || RST) ? '0 : mem_rd[rd_ptr];
    assign wb_rd_data   = (empty || RST) ? '0 : mem_data[rd_ptr];
    assign wb_rd_wen    = pop & mem_wen[rd_ptr];
    assign wb_align_err = align_err_q & ~RST;
    assign retire_cnt   = retire_q;

`ifdef WB_FWD_EN
    logic            fwd_hit_c;
    logic [XLEN-1:0] fwd_data_c;
    logic [PW-1:0]   fwd_idx;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        fwd_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if ((PW+1)'(i) < count && mem_wen[fwd_idx] &&
                mem_rd[fwd_idx] == fwd_rs && fwd_rs != '0) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = mem_data[fwd_idx];
            end
        end
    end

    assign fwd_hit  = fwd_hit_c & ~RST;
    assign fwd_data = RST ? '0 : fwd_data_c;
`else
    logic unused_fwd_rs;
    assign unused_fwd_rs = ^fwd_rs;
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_wb_stage_q.sv
// Directed bench for wb_stage_q: alignment vector table, stall/fill ordering,
// forwarding, reset mid-queue and a 64-bit alignment instance.
module tb_wb_stage_q;

    typedef struct {
        logic        mem_sel;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [3:0]  rstrb;
        logic        lsign;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_wen;
        logic        exp_err;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_alu_data;
    logic        in_mem_sel;
    logic [31:0] in_mem_rdata;
    logic [3:0]  in_rstrb;
    logic        in_lsign;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        wb_stall;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rd_data;
    logic        wb_rd_wen;
    logic        wb_align_err;
    logic [31:0] retire_cnt;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    logic        d64_vld;
    logic        d64_rdy;
    logic [63:0] d64_rdata;
    logic [7:0]  d64_rstrb;
    logic        d64_lsign;
    logic [4:0]  d64_wb_rd;
    logic [63:0] d64_wb_data;
    logic        d64_wb_wen;
    logic        d64_err;
    logic [31:0] d64_retire;
    logic        d64_fwd_hit;
    logic [63:0] d64_fwd_data;

    int n_compared   = 0;
    int n_mismatched = 0;
    int exp_retire   = 0;
    vec_t vecs [15];

    always #5 CLK = ~CLK;

    wb_stage_q dut (
        .CLK(CLK), .RST(RST),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in_alu_data(in_alu_data), .in_mem_sel(in_mem_sel),
        .in_mem_rdata(in_mem_rdata), .in_rstrb(in_rstrb),
        .in_lsign(in_lsign), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .wb_stall(wb_stall), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
        .wb_rd_wen(wb_rd_wen), .wb_align_err(wb_align_err),
        .retire_cnt(retire_cnt), .fwd_rs(fwd_rs),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    wb_stage_q #(.XLEN(64)) dut64 (
        .CLK(CLK), .RST(RST),
        .in_vld(d64_vld), .in_rdy(d64_rdy),
        .in_alu_data(64'h0), .in_mem_sel(1'b1),
        .in_mem_rdata(d64_rdata), .in_rstrb(d64_rstrb),
        .in_lsign(d64_lsign), .in_rd(5'd4), .in_rd_wen(1'b1),
        .wb_stall(1'b0), .wb_rd(d64_wb_rd), .wb_rd_data(d64_wb_data),
        .wb_rd_wen(d64_wb_wen), .wb_align_err(d64_err),
        .retire_cnt(d64_retire), .fwd_rs(5'd0),
        .fwd_hit(d64_fwd_hit), .fwd_data(d64_fwd_data)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_vld       = 1'b1;
        in_mem_sel   = v.mem_sel;
        in_alu_data  = v.alu;
        in_mem_rdata = v.rdata;
        in_rstrb     = v.rstrb;
        in_lsign     = v.lsign;
        in_rd        = v.rd;
        in_rd_wen    = v.rd_wen;
    endtask

    task automatic pushAlu(input logic [4:0] rd, input logic [31:0] data);
        in_vld      = 1'b1;
        in_mem_sel  = 1'b0;
        in_alu_data = data;
        in_rd       = rd;
        in_rd_wen   = 1'b1;
    endtask

    task automatic check64(input string name, input logic [7:0] strb,
                           input logic [63:0] rdata, input logic sgn, input logic [63:0] exp);
        @(negedge CLK);
        d64_vld = 1'b1; d64_rstrb = strb; d64_rdata = rdata; d64_lsign = sgn;
        @(posedge CLK); #1;
        checkOutput(name, d64_wb_data, exp);
        @(negedge CLK);
        d64_vld = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0, 32'h0080_0000, 4'b0100, 1'b1, 5'd5,  1'b1, 5'd5,  32'hFFFF_FF80, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h0, 32'h0080_0000, 4'b0100, 1'b0, 5'd5,  1'b1, 5'd5,  32'h0000_0080, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h0, 32'h8123_4567, 4'b1100, 1'b0, 5'd6,  1'b1, 5'd6,  32'h0000_8123, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h0, 32'h8123_4567, 4'b1100, 1'b1, 5'd6,  1'b1, 5'd6,  32'hFFFF_8123, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h0, 32'h8123_4567, 4'b0110, 1'b1, 5'd8,  1'b1, 5'd8,  32'h8123_4567, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 4'b0110, 1'b1, 5'd10, 1'b1, 5'd10, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'h0, 32'hA5A5_0001, 4'b0000, 1'b1, 5'd11, 1'b1, 5'd11, 32'hA5A5_0001, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h0, 32'h8000_00F0, 4'b1111, 1'b1, 5'd12, 1'b1, 5'd12, 32'h8000_00F0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 32'h0, 32'h0000_00FF, 4'b0001, 1'b1, 5'd13, 1'b1, 5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h0, 32'h7F00_0000, 4'b1000, 1'b1, 5'd14, 1'b1, 5'd14, 32'h0000_007F, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'h0, 32'hFFFF_8000, 4'b0011, 1'b0, 5'd15, 1'b1, 5'd15, 32'h0000_8000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0055, 32'h0, 4'b0000, 1'b0, 5'd0, 1'b1, 5'd0, 32'h0000_0055, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h1234_0000, 32'h0, 4'b0000, 1'b0, 5'd3, 1'b0, 5'd3, 32'h1234_0000, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'h0, 32'hCAFE_F00D, 4'b1010, 1'b0, 5'd9, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 32'h0, 32'hCAFE_F00D, 4'b0111, 1'b0, 5'd9, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b1, 1'b1};

        RST = 1'b1; in_vld = 1'b0; in_alu_data = '0; in_mem_sel = 1'b0; in_mem_rdata = '0;
        in_rstrb = '0; in_lsign = 1'b0; in_rd = '0; in_rd_wen = 1'b0; wb_stall = 1'b0; fwd_rs = '0;
        d64_vld = 1'b0; d64_rdata = '0; d64_rstrb = '0; d64_lsign = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_in_rdy", 64'(in_rdy), 64'd0);
        checkOutput("rst_wb_rd_wen", 64'(wb_rd_wen), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkOutput("post_rst_in_rdy", 64'(in_rdy), 64'd1);
        checkOutput("post_rst_retire", 64'(retire_cnt), 64'd0);
        checkOutput("post_rst_err", 64'(wb_align_err), 64'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            applyStimulus(vecs[i]);
            @(posedge CLK); #1;
            checkOutput($sformatf("v%0d_rd", i), 64'(wb_rd), 64'(vecs[i].exp_rd));
            checkOutput($sformatf("v%0d_data", i), 64'(wb_rd_data), 64'(vecs[i].exp_data));
            checkOutput($sformatf("v%0d_wen", i), 64'(wb_rd_wen), 64'(vecs[i].exp_wen));
            checkOutput($sformatf("v%0d_err", i), 64'(wb_align_err), 64'(vecs[i].exp_err));
            @(negedge CLK);
            in_vld = 1'b0;
            @(posedge CLK); #1;
            exp_retire++;
            checkOutput($sformatf("v%0d_retire", i), 64'(retire_cnt), 64'(exp_retire));
            checkOutput($sformatf("v%0d_err_clr", i), 64'(wb_align_err), 64'd0);
            checkOutput($sformatf("v%0d_empty_wen", i), 64'(wb_rd_wen), 64'd0);
        end

        // Stall, fill the 2-deep queue, then drain in order.
        @(negedge CLK);
        wb_stall = 1'b1;
        pushAlu(5'd1, 32'h101);
        @(posedge CLK); #1;
        checkOutput("fill1_in_rdy", 64'(in_rdy), 64'd1);
        @(negedge CLK);
        pushAlu(5'd2, 32'h102);
        @(posedge CLK); #1;
        checkOutput("fill2_in_rdy", 64'(in_rdy), 64'd0);
        @(negedge CLK);
        pushAlu(5'd3, 32'h103);
        @(posedge CLK); #1;
        checkOutput("stall_in_rdy", 64'(in_rdy), 64'd0);
        checkOutput("stall_wen", 64'(wb_rd_wen), 64'd0);
        checkOutput("stall_head", 64'(wb_rd), 64'd1);
        @(negedge CLK);
        wb_stall = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checkOutput($sformatf("drain%0d_rd", k), 64'(wb_rd), 64'(k));
            checkOutput($sformatf("drain%0d_data", k), 64'(wb_rd_data), 64'(32'h100 + k));
            checkOutput($sformatf("drain%0d_wen", k), 64'(wb_rd_wen), 64'd1);
            @(posedge CLK); #1;
            if (k == 2) in_vld = 1'b0;
            @(negedge CLK);
        end
        exp_retire += 3;
        #1;
        checkOutput("drain_retire", 64'(retire_cnt), 64'(exp_retire));
        checkOutput("drain_empty_wen", 64'(wb_rd_wen), 64'd0);

        // Two results for the same register queued behind a stall.
        wb_stall = 1'b1;
        pushAlu(5'd7, 32'h11);
        @(posedge CLK); #1;
        @(negedge CLK);
        pushAlu(5'd7, 32'h22);
        @(posedge CLK); #1;
        in_vld = 1'b0;
        fwd_rs = 5'd7;
        #1;
`ifdef WB_FWD_EN
        checkOutput("fwd7_hit", 64'(fwd_hit), 64'd1);
        checkOutput("fwd7_data", 64'(fwd_data), 64'h22);
`else
        checkOutput("fwd7_hit", 64'(fwd_hit), 64'd0);
        checkOutput("fwd7_data", 64'(fwd_data), 64'd0);
`endif
        fwd_rs = 5'd0;
        #1;
        checkOutput("fwd0_hit", 64'(fwd_hit), 64'd0);
        fwd_rs = 5'd3;
        #1;
        checkOutput("fwd3_hit", 64'(fwd_hit), 64'd0);

        // Reset with two entries queued: they must never reach the register file.
        @(negedge CLK);
        RST = 1'b1;
        wb_stall = 1'b0;
        fwd_rs = 5'd7;
        #1;
        checkOutput("midrst_in_rdy", 64'(in_rdy), 64'd0);
        checkOutput("midrst_wen", 64'(wb_rd_wen), 64'd0);
        checkOutput("midrst_rd", 64'(wb_rd), 64'd0);
        checkOutput("midrst_data", 64'(wb_rd_data), 64'd0);
        checkOutput("midrst_fwd", 64'(fwd_hit), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkOutput("after_rst_in_rdy", 64'(in_rdy), 64'd1);
        checkOutput("after_rst_retire", 64'(retire_cnt), 64'd0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("after_rst_wen%0d", k), 64'(wb_rd_wen), 64'd0);
            @(negedge CLK); #1;
        end
        checkOutput("after_rst_retire_hold", 64'(retire_cnt), 64'd0);
        checkOutput("after_rst_fwd", 64'(fwd_hit), 64'd0);

        check64("x64_word_hi", 8'hF0, 64'h8000_0001_1234_5678, 1'b1, 64'hFFFF_FFFF_8000_0001);
        check64("x64_byte5", 8'h20, 64'h0000_8000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        check64("x64_word_lo", 8'h0F, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0000_0000_9ABC_DEF0);
        check64("x64_dword", 8'hFF, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h1234_5678_9ABC_DEF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
